// File: rtl/dm_sba_pkg.sv
// Shared types for the system bus access engine: FSM states, sberror codes
// and sbaccess size encodings.
package dm_sba_pkg;

    typedef enum logic [2:0] {
        SBA_IDLE       = 3'd0,
        SBA_READ       = 3'd1,
        SBA_WRITE      = 3'd2,
        SBA_WAIT_READ  = 3'd3,
        SBA_WAIT_WRITE = 3'd4
    } sba_state_e;

    typedef enum logic [2:0] {
        SBERR_NONE    = 3'd0,
        SBERR_BADADDR = 3'd2,
        SBERR_ALIGN   = 3'd3,
        SBERR_SIZE    = 3'd4,
        SBERR_OTHER   = 3'd7
    } sberror_e;

    localparam logic [2:0] SBACCESS_8  = 3'd0;
    localparam logic [2:0] SBACCESS_16 = 3'd1;
    localparam logic [2:0] SBACCESS_32 = 3'd2;
    localparam logic [2:0] SBACCESS_64 = 3'd3;

    // Largest legal sbaccess for a given bus width (32 or 64 bits).
    function automatic logic [2:0] max_sbaccess(input int unsigned bus_width);
        return (bus_width == 64) ? SBACCESS_64 : SBACCESS_32;
    endfunction

endpackage

// File: rtl/dm_sba_if.sv
// Debug module bus master port: request side plus single-beat response.
interface dm_sba_if #(
    parameter int unsigned BusWidth = 32
) ();
    logic                  req;
    logic                  we;
    logic [BusWidth-1:0]   addr;
    logic [BusWidth-1:0]   wdata;
    logic [BusWidth/8-1:0] be;
    logic                  gnt;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_other_err;
    logic [BusWidth-1:0]   r_rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, r_valid, r_err, r_other_err, r_rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, r_valid, r_err, r_other_err, r_rdata
    );
endinterface

// File: rtl/dm_sba.sv
// System bus access engine: turns sbaddress/sbdata register events into single
// bus transfers, with lane alignment, access checks and auto-increment.
module dm_sba
    import dm_sba_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter bit          ReadByteEnable = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                dmactive_i,
    input  logic [BusWidth-1:0] sbaddress_i,
    input  logic                sbaddress_write_valid_i,
    input  logic                sbreadonaddr_i,
    output logic [BusWidth-1:0] sbaddress_o,
    input  logic                sbautoincrement_i,
    input  logic [2:0]          sbaccess_i,
    input  logic                sbreadondata_i,
    input  logic [BusWidth-1:0] sbdata_i,
    input  logic                sbdata_read_valid_i,
    input  logic                sbdata_write_valid_i,
    output logic [BusWidth-1:0] sbdata_o,
    output logic                sbdata_valid_o,
    output logic                sbbusy_o,
    output logic                sberror_valid_o,
    output logic [2:0]          sberror_o,
    dm_sba_if.master            bus
);

    localparam int unsigned BeWidth   = BusWidth / 8;
    localparam int unsigned OffWidth  = $clog2(BeWidth);
    localparam int unsigned PosWidth  = OffWidth + 2;
    localparam logic [2:0]  MaxAccess = max_sbaccess(BusWidth);

    sba_state_e            state_reg, state_next;
    logic [BusWidth-1:0]   addr_reg;
    logic [2:0]            acc_reg;
    logic [OffWidth-1:0]   off_reg;
    logic                  autoinc_reg;
    logic [BeWidth-1:0]    be_reg;
    logic [BusWidth-1:0]   wdata_reg;
    logic [BusWidth-1:0]   rdata_reg;
    logic                  rdata_valid_reg;
    sberror_e              err_reg;
    logic                  err_valid_reg;
    logic                  done_reg;

    logic                  in_idle;
    logic                  start_write;
    logic                  start_read;
    logic                  start_any;
    logic                  size_err;
    logic                  align_err;
    logic                  resp_accept;
    logic                  req_next;
    logic                  we_next;
    logic [BusWidth-1:0]   eff_addr;
    logic [BusWidth-1:0]   align_mask;
    logic [BusWidth-1:0]   start_wdata;
    logic [BusWidth-1:0]   rdata_shifted;
    logic [BusWidth-1:0]   rdata_mask;
    logic [OffWidth-1:0]   start_off;
    logic [PosWidth-1:0]   start_nbytes;
    logic [PosWidth-1:0]   acc_nbytes;
    logic [BeWidth-1:0]    start_be;

    // Start decode; a write wins over a coincident read.
    assign in_idle     = (state_reg == SBA_IDLE);
    assign start_write = in_idle && sbdata_write_valid_i;
    assign start_read  = in_idle && ((sbaddress_write_valid_i && sbreadonaddr_i) ||
                                     (sbdata_read_valid_i && sbreadondata_i));
    assign start_any   = start_write || start_read;

    // An address-triggered access must see the address being written this cycle.
    assign eff_addr     = sbaddress_write_valid_i ? sbaddress_i : addr_reg;
    assign align_mask   = (BusWidth'(1) << sbaccess_i) - BusWidth'(1);
    assign size_err     = (sbaccess_i > MaxAccess);
    assign align_err    = |(eff_addr & align_mask);
    assign start_off    = eff_addr[OffWidth-1:0];
    assign start_nbytes = PosWidth'(1) << sbaccess_i[1:0];
    assign start_wdata  = sbdata_i << {start_off, 3'b000};

    assign acc_nbytes    = PosWidth'(1) << acc_reg[1:0];
    assign rdata_shifted = bus.r_rdata >> {off_reg, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < BeWidth; gi++) begin : g_lane
            localparam logic [PosWidth-1:0] Lane = PosWidth'(gi);
            assign start_be[gi] = (Lane >= PosWidth'(start_off)) &&
                                  (Lane <  PosWidth'(start_off) + start_nbytes);
            assign rdata_mask[8*gi +: 8] = {8{Lane < acc_nbytes}};
        end
    endgenerate

    assign resp_accept = ((state_reg == SBA_WAIT_READ) || (state_reg == SBA_WAIT_WRITE)) &&
                         bus.r_valid;

    always_comb begin
        state_next = state_reg;
        req_next   = 1'b0;
        we_next    = 1'b0;
        case (state_reg)
            SBA_IDLE: begin
                if (start_any && !size_err && !align_err) begin
                    state_next = start_write ? SBA_WRITE : SBA_READ;
                end
            end
            SBA_READ: begin
                req_next = 1'b1;
                if (bus.gnt) begin
                    state_next = SBA_WAIT_READ;
                end
            end
            SBA_WRITE: begin
                req_next = 1'b1;
                we_next  = 1'b1;
                if (bus.gnt) begin
                    state_next = SBA_WAIT_WRITE;
                end
            end
            SBA_WAIT_READ, SBA_WAIT_WRITE: begin
                if (bus.r_valid) begin
                    state_next = SBA_IDLE;
                end
            end
            default: state_next = SBA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !dmactive_i) begin
            state_reg       <= SBA_IDLE;
            addr_reg        <= '0;
            acc_reg         <= '0;
            off_reg         <= '0;
            autoinc_reg     <= 1'b0;
            be_reg          <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            err_reg         <= SBERR_NONE;
            err_valid_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rdata_valid_reg <= 1'b0;
            err_valid_reg   <= 1'b0;
            err_reg         <= SBERR_NONE;
            done_reg        <= resp_accept;

            if (in_idle && sbaddress_write_valid_i) begin
                addr_reg <= sbaddress_i;
            end

            // Size and lane setup are frozen here so later CSR changes cannot
            // disturb the transfer in flight.
            if (start_any) begin
                if (size_err) begin
                    err_valid_reg <= 1'b1;
                    err_reg       <= SBERR_SIZE;
                end else if (align_err) begin
                    err_valid_reg <= 1'b1;
                    err_reg       <= SBERR_ALIGN;
                end else begin
                    acc_reg     <= sbaccess_i;
                    off_reg     <= start_off;
                    autoinc_reg <= sbautoincrement_i;
                    wdata_reg   <= start_wdata;
                    be_reg      <= (start_write || ReadByteEnable) ? start_be : '1;
                end
            end

            if (resp_accept) begin
                if (bus.r_other_err) begin
                    err_valid_reg <= 1'b1;
                    err_reg       <= SBERR_OTHER;
                end else if (bus.r_err) begin
                    err_valid_reg <= 1'b1;
                    err_reg       <= SBERR_BADADDR;
                end else begin
                    if (state_reg == SBA_WAIT_READ) begin
                        rdata_reg       <= rdata_shifted & rdata_mask;
                        rdata_valid_reg <= 1'b1;
                    end
                    if (autoinc_reg) begin
                        addr_reg <= addr_reg + (BusWidth'(1) << acc_reg);
                    end
                end
            end
        end
    end

    assign bus.req   = req_next;
    assign bus.we    = we_next;
    assign bus.addr  = addr_reg;
    assign bus.wdata = wdata_reg;
    assign bus.be    = be_reg;

    // Busy stays up through the cycle that delivers the result strobe.
    assign sbbusy_o        = !in_idle || done_reg;
    assign sbaddress_o     = addr_reg;
    assign sbdata_o        = rdata_reg;
    assign sbdata_valid_o  = rdata_valid_reg;
    assign sberror_valid_o = err_valid_reg;
    assign sberror_o       = err_reg;

endmodule

// File: tb/tb_dm_sba.sv
// Directed bench for dm_sba: a transaction-level model predicts every cycle's
// expected outputs, and a negedge compare process checks the DUT against it.
module tb_dm_sba;

    logic        clk;
    logic        rst_n;
    logic        dmactive;
    logic [31:0] sbaddress;
    logic        sbaddress_write_valid;
    logic        sbreadonaddr;
    logic [31:0] sbaddress_out;
    logic        sbautoinc;
    logic [2:0]  sbaccess;
    logic        sbreadondata;
    logic [31:0] sbdata;
    logic        sbdata_read_valid;
    logic        sbdata_write_valid;
    logic [31:0] sbdata_out;
    logic        sbdata_valid;
    logic        sbbusy;
    logic        sberror_valid;
    logic [2:0]  sberror;

    dm_sba_if #(.BusWidth(32)) bus ();

    dm_sba #(.BusWidth(32), .ReadByteEnable(1'b1)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .dmactive_i              (dmactive),
        .sbaddress_i             (sbaddress),
        .sbaddress_write_valid_i (sbaddress_write_valid),
        .sbreadonaddr_i          (sbreadonaddr),
        .sbaddress_o             (sbaddress_out),
        .sbautoincrement_i       (sbautoinc),
        .sbaccess_i              (sbaccess),
        .sbreadondata_i          (sbreadondata),
        .sbdata_i                (sbdata),
        .sbdata_read_valid_i     (sbdata_read_valid),
        .sbdata_write_valid_i    (sbdata_write_valid),
        .sbdata_o                (sbdata_out),
        .sbdata_valid_o          (sbdata_valid),
        .sbbusy_o                (sbbusy),
        .sberror_valid_o         (sberror_valid),
        .sberror_o               (sberror),
        .bus                     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state and per-cycle expectations.
    logic [31:0] m_addr;
    logic        chk_en;
    logic        exp_busy, exp_req, exp_we, exp_dv, exp_ev;
    logic [31:0] exp_add, exp_wdata, exp_data, exp_sbaddr;
    logic [3:0]  exp_be;
    logic [2:0]  exp_err;

    // Observations captured by the compare process for literal checks.
    logic [31:0] cap_data, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [2:0]  cap_err;
    logic [31:0] cap_add [8];
    int          n_gnt = 0, busy_cnt = 0, req_cnt = 0, dv_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", sbbusy, exp_busy);
            check("req", bus.req, exp_req);
            check("data_valid", sbdata_valid, exp_dv);
            check("error_valid", sberror_valid, exp_ev);
            check("sbaddress", sbaddress_out, exp_sbaddr);
            if (exp_req) begin
                check("we", bus.we, exp_we);
                check("bus_addr", bus.addr, exp_add);
                check("be", bus.be, exp_be);
                if (exp_we) check("wdata", bus.wdata, exp_wdata);
            end
            if (exp_dv) check("rdata", sbdata_out, exp_data);
            if (exp_ev) check("sberror", sberror, exp_err);
        end
        if (bus.req) begin
            req_cnt++;
            cap_be    = bus.be;
            cap_wdata = bus.wdata;
            cap_we    = bus.we;
            if (bus.gnt) begin
                cap_add[n_gnt % 8] = bus.addr;
                n_gnt++;
            end
        end
        if (sbbusy) busy_cnt++;
        if (sbdata_valid) begin
            dv_cnt++;
            cap_data = sbdata_out;
        end
        if (sberror_valid) cap_err = sberror;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        exp_busy   = 1'b0;
        exp_req    = 1'b0;
        exp_we     = 1'b0;
        exp_dv     = 1'b0;
        exp_ev     = 1'b0;
        exp_sbaddr = m_addr;
    endtask

    task automatic clear_strobes();
        sbaddress_write_valid = 1'b0;
        sbreadonaddr          = 1'b0;
        sbdata_write_valid    = 1'b0;
        sbdata_read_valid     = 1'b0;
        sbreadondata          = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a);
        sbaddress             = a;
        sbaddress_write_valid = 1'b1;
        sbreadonaddr          = 1'b0;
        m_addr                = a;
        cyc();
        clear_strobes();
    endtask

    // trig: 0 sbdata write, 1 sbaddress write + readonaddr,
    //       2 sbdata read + readondata, 3 sbdata write + address read (write wins)
    // rsp_kind: 0 ok, 1 r_err, 2 r_err + r_other_err
    task automatic access(input bit wr, input int trig, input logic [31:0] new_addr,
                          input logic [2:0] acc, input logic [31:0] data, input bit ainc,
                          input int gnt_wait, input int rsp_wait, input int rsp_kind,
                          input logic [31:0] rdata);
        logic [31:0] eff;
        int          off, nbytes;
        bit          bad_size, bad_align;
        eff                   = (trig == 1 || trig == 3) ? new_addr : m_addr;
        sbaccess              = acc;
        sbdata                = data;
        sbautoinc             = ainc;
        sbaddress             = new_addr;
        sbdata_write_valid    = (trig == 0 || trig == 3);
        sbaddress_write_valid = (trig == 1 || trig == 3);
        sbreadonaddr          = (trig == 1 || trig == 3);
        sbdata_read_valid     = (trig == 2);
        sbreadondata          = (trig == 2);
        if (trig == 1 || trig == 3) m_addr = new_addr;
        bad_size  = (acc > 3'd2);
        nbytes    = 1 << acc;
        bad_align = !bad_size && ((eff % nbytes) != 0);
        off       = eff % 4;
        cyc();
        clear_strobes();
        if (bad_size || bad_align) begin
            exp_ev  = 1'b1;
            exp_err = bad_size ? 3'd4 : 3'd3;
            $display("txn %s addr=0x%0h size=%0d rejected, sberror=%0d",
                     wr ? "write" : "read", eff, acc, exp_err);
            return;
        end
        for (int g = 0; g <= gnt_wait; g++) begin
            exp_busy  = 1'b1;
            exp_req   = 1'b1;
            exp_we    = wr;
            exp_add   = eff;
            exp_be    = 4'(((1 << nbytes) - 1) << off);
            exp_wdata = data << (8 * off);
            bus.gnt   = (g == gnt_wait);
            cyc();
        end
        bus.gnt = 1'b0;
        for (int r = 0; r <= rsp_wait; r++) begin
            exp_busy        = 1'b1;
            bus.r_valid     = (r == rsp_wait);
            bus.r_err       = (r == rsp_wait) && (rsp_kind != 0);
            bus.r_other_err = (r == rsp_wait) && (rsp_kind == 2);
            bus.r_rdata     = rdata;
            cyc();
        end
        bus.r_valid     = 1'b0;
        bus.r_err       = 1'b0;
        bus.r_other_err = 1'b0;
        exp_busy        = 1'b1;
        if (rsp_kind == 0) begin
            if (!wr) begin
                exp_dv   = 1'b1;
                exp_data = 32'((64'(rdata) >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 64'd1));
            end
            if (ainc) begin
                m_addr     = m_addr + 32'(nbytes);
                exp_sbaddr = m_addr;
            end
        end else begin
            exp_ev  = 1'b1;
            exp_err = (rsp_kind == 2) ? 3'd7 : 3'd2;
        end
        $display("txn %s addr=0x%0h size=%0d data=0x%0h gnt_wait=%0d rsp_wait=%0d rsp=%0d",
                 wr ? "write" : "read", eff, acc, wr ? data : rdata, gnt_wait, rsp_wait, rsp_kind);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0, d0;
        chk_en          = 1'b0;
        m_addr          = 32'h0;
        rst_n           = 1'b0;
        dmactive        = 1'b1;
        sbaddress       = 32'h0;
        sbautoinc       = 1'b0;
        sbaccess        = 3'd2;
        sbdata          = 32'h0;
        clear_strobes();
        bus.gnt         = 1'b0;
        bus.r_valid     = 1'b0;
        bus.r_err       = 1'b0;
        bus.r_other_err = 1'b0;
        bus.r_rdata     = 32'h0;
        cyc();
        cyc();
        check("rst_busy", sbbusy, 0);
        check("rst_req", bus.req, 0);
        check("rst_we", bus.we, 0);
        check("rst_add", bus.addr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_be", bus.be, 0);
        check("rst_sbdata", sbdata_out, 0);
        check("rst_dvalid", sbdata_valid, 0);
        check("rst_evalid", sberror_valid, 0);
        check("rst_err", sberror, 0);
        check("rst_sbaddr", sbaddress_out, 0);
        rst_n = 1'b1;
        cyc();
        chk_en = 1'b1;

        // Address-triggered read, zero-wait grant, response next cycle.
        b0 = busy_cnt;
        access(0, 1, 32'h100, 3'd2, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF);
        cyc();
        check("lit_read_data", cap_data, 32'hDEADBEEF);
        check("lit_busy_cycles", busy_cnt - b0, 3);

        // Byte write into the top lane.
        set_addr(32'h103);
        access(1, 0, 32'h0, 3'd0, 32'hA5, 0, 1, 1, 0, 32'h0);
        cyc();
        check("lit_be", cap_be, 4'b1000);
        check("lit_wdata", cap_wdata, 32'hA500_0000);
        check("lit_we", cap_we, 1);

        // Auto-incrementing word writes.
        set_addr(32'h200);
        n_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            access(1, 0, 32'h0, 3'd2, 32'h1111_0000 + 32'(i), 1, i, i, 0, 32'h0);
        end
        cyc();
        check("lit_add0", cap_add[0], 32'h200);
        check("lit_add1", cap_add[1], 32'h204);
        check("lit_add2", cap_add[2], 32'h208);
        check("lit_sbaddr", sbaddress_out, 32'h20C);

        // Data-triggered halfword read from the upper half.
        set_addr(32'h20E);
        access(0, 2, 32'h0, 3'd1, 32'h0, 0, 2, 1, 0, 32'h1234_5678);
        cyc();
        check("lit_half", cap_data, 32'h1234);

        // Bus errors: no data strobe, no increment even with autoincrement on.
        d0 = dv_cnt;
        access(0, 1, 32'h100, 3'd2, 32'h0, 1, 0, 0, 1, 32'hFFFF_FFFF);
        cyc();
        check("lit_err2", cap_err, 3'd2);
        access(0, 2, 32'h0, 3'd2, 32'h0, 1, 1, 0, 2, 32'hFFFF_FFFF);
        cyc();
        check("lit_err7", cap_err, 3'd7);
        check("lit_err_no_dv", dv_cnt - d0, 0);
        check("lit_err_addr", sbaddress_out, 32'h100);

        // Rejected accesses never reach the bus.
        r0 = req_cnt;
        access(0, 1, 32'h100, 3'd3, 32'h0, 0, 0, 0, 0, 32'h0);
        cyc();
        check("lit_err4", cap_err, 3'd4);
        access(0, 1, 32'h102, 3'd2, 32'h0, 0, 0, 0, 0, 32'h0);
        cyc();
        check("lit_err3", cap_err, 3'd3);
        check("lit_no_req", req_cnt - r0, 0);

        // Write and address-read in the same cycle: the write wins at the new address.
        access(1, 3, 32'h300, 3'd2, 32'hCAFE_F00D, 0, 0, 2, 0, 32'h0);
        cyc();
        check("lit_ww_we", cap_we, 1);
        check("lit_ww_wdata", cap_wdata, 32'hCAFE_F00D);

        // Grant stalled 5 cycles, then dmactive drops mid-request.
        d0 = dv_cnt;
        sbaccess              = 3'd2;
        sbaddress             = 32'h400;
        sbaddress_write_valid = 1'b1;
        sbreadonaddr          = 1'b1;
        m_addr                = 32'h400;
        cyc();
        clear_strobes();
        for (int i = 0; i < 5; i++) begin
            exp_busy = 1'b1;
            exp_req  = 1'b1;
            exp_we   = 1'b0;
            exp_add  = 32'h400;
            exp_be   = 4'hF;
            cyc();
        end
        exp_busy = 1'b1;
        exp_req  = 1'b1;
        exp_add  = 32'h400;
        exp_be   = 4'hF;
        dmactive = 1'b0;
        m_addr   = 32'h0;
        cyc();
        dmactive = 1'b1;
        cyc();
        bus.r_valid = 1'b1;
        bus.r_rdata = 32'h5555_AAAA;
        cyc();
        bus.r_valid = 1'b0;
        cyc();
        cyc();
        check("lit_abort_no_dv", dv_cnt - d0, 0);
        check("lit_abort_req", bus.req, 0);
        $display("txn read addr=0x400 abandoned by dmactive low");

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
